// File: rtl/d_mem_resp.sv
// d_mem_resp -- data-memory responder (slave side of the CPU data port).
//
// Accepts one request at a time with a valid/ready handshake.
// The request is held for LATENCY wait states, and then the access is performed.
// A one-cycle response strobe follows.
// The block also keeps the LL/SC reservation, so the CPU only sees a pass/fail result.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid     request present
//   req_ready     high only while idle
//   req_addr      word address
//   req_wdata     write data
//   req_rw_       0 = write, 1 = read
//   req_byte_en   per-byte write enables
//   req_ll        load-linked (honoured on reads only)
//   req_sc        store-conditional (honoured on writes only)
//   resp_valid    one-cycle response strobe
//   resp_rdata    read data (0 for writes and errors)
//   resp_sc_ok    store-conditional succeeded
//   resp_err      address outside the served range
module d_mem_resp #(
   parameter int BITS      = 32,
   parameter int WORDS     = 256,
   parameter int BASE_ADDR = 0,
   parameter int LATENCY   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [BITS-1:0] req_addr,
   input  logic [BITS-1:0] req_wdata,
   input  logic            req_rw_,
   input  logic [3:0]      req_byte_en,
   input  logic            req_ll,
   input  logic            req_sc,
   output logic            resp_valid,
   output logic [BITS-1:0] resp_rdata,
   output logic            resp_sc_ok,
   output logic            resp_err
);

   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LANES = 4;
   // Range bounds carry one extra bit so BASE_ADDR+WORDS cannot wrap.
   localparam logic [BITS:0] ADDR_LO = (BITS+1)'(BASE_ADDR);
   localparam logic [BITS:0] ADDR_HI = (BITS+1)'(BASE_ADDR) + (BITS+1)'(WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;

   logic [BITS-1:0] addr_reg, wdata_reg;
   logic            rw_reg, ll_reg, sc_reg;
   logic [3:0]      be_reg;

   logic            link_valid_reg;
   logic [BITS-1:0] link_addr_reg;
   logic            resp_valid_reg, resp_sc_ok_reg, resp_err_reg;

   logic            accept, access, in_range, sc_pass, do_write;
   logic [AW-1:0]   idx;

   assign req_ready = (state_reg == IDLE);
   assign accept    = req_ready && req_valid;
   // The access happens on the edge that leaves WAIT.
   assign access    = (state_reg == WAIT) && (cnt_reg == 4'd0);

   assign in_range  = ({1'b0, addr_reg} >= ADDR_LO) && ({1'b0, addr_reg} < ADDR_HI);
   assign idx       = AW'(addr_reg - BITS'(BASE_ADDR));
   assign sc_pass   = !rw_reg && sc_reg && in_range &&
                      link_valid_reg && (link_addr_reg == addr_reg);
   // A reset coinciding with the access edge drops the pending write.
   assign do_write  = access && !rst && !rw_reg && in_range && (!sc_reg || sc_pass);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // FSM next state
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: if (req_valid) begin
            state_next = WAIT;
            cnt_next   = 4'(LATENCY - 1);
         end
         WAIT: if (cnt_reg == 4'd0) state_next = RESP;
               else                 cnt_next   = cnt_reg - 4'd1;
         RESP: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request capture: fields are sampled only on the accept edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg  <= '0;
         wdata_reg <= '0;
         rw_reg    <= 1'b0;
         be_reg    <= 4'd0;
         ll_reg    <= 1'b0;
         sc_reg    <= 1'b0;
      end else if (accept) begin
         addr_reg  <= req_addr;
         wdata_reg <= req_wdata;
         rw_reg    <= req_rw_;
         be_reg    <= req_byte_en;
         ll_reg    <= req_ll;
         sc_reg    <= req_sc;
      end
   end

   // Response flags and reservation
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid_reg <= 1'b0;
         resp_sc_ok_reg <= 1'b0;
         resp_err_reg   <= 1'b0;
         link_valid_reg <= 1'b0;
         link_addr_reg  <= '0;
      end else begin
         resp_valid_reg <= access;
         if (access) begin
            resp_err_reg   <= !in_range;
            resp_sc_ok_reg <= sc_pass;
            if (!rw_reg && sc_reg) begin
               // Every SC consumes the reservation, even out of range.
               link_valid_reg <= 1'b0;
            end else if (rw_reg && ll_reg && in_range) begin
               link_valid_reg <= 1'b1;
               link_addr_reg  <= addr_reg;
            end else if (!rw_reg && in_range && (addr_reg == link_addr_reg)) begin
               link_valid_reg <= 1'b0;
            end
         end
      end
   end

   // Storage is split into byte lanes.
   // Each lane is a simple RAM with a per-lane write enable and a registered read.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [7:0] mem [WORDS];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (do_write && be_reg[gi])
               mem[idx] <= wdata_reg[8*gi +: 8];
         end

         always_ff @(posedge clk) begin
            if (rst)
               rd_reg <= 8'h00;
            else if (access)
               rd_reg <= (rw_reg && in_range) ? mem[idx] : 8'h00;
         end

         assign resp_rdata[8*gi +: 8] = rd_reg;
      end
   endgenerate

   assign resp_valid = resp_valid_reg;
   assign resp_sc_ok = resp_sc_ok_reg;
   assign resp_err   = resp_err_reg;

endmodule
